// File: rtl/audio_pkg.sv
// Shared constants for the audio sample path.
//   SMPL_W           - width of a signed audio sample
//   RATE_DIV_DEFAULT - clk cycles per sample period (50 MHz / 48 kHz)
//   ST_PRIME, ST_RUN - state encoding of the sample buffer FSM
package audio_pkg;

  localparam int unsigned SMPL_W           = 18;
  localparam int unsigned RATE_DIV_DEFAULT = 1042;

  localparam logic ST_PRIME = 1'b0;
  localparam logic ST_RUN   = 1'b1;

endpackage

// File: rtl/smpl_fifo.sv
// Single-clock synchronous FIFO with a registered memory read.
// The read data register (head) loads on a pop, so the popped word is
// presented the cycle after the pop and held until the next pop.
// Ports:
//   clk, reset         - clock, asynchronous active-low reset
//   push, push_data    - write request and data (ignored while full)
//   pop                - read request (ignored while empty)
//   full, empty, level - occupancy status, level in 0..2^DEPTH_LOG2
//   head               - data of the most recent pop
module smpl_fifo
  import audio_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned WIDTH      = SMPL_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic [WIDTH-1:0]      head
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q, level_d;
  logic [WIDTH-1:0]      head_q;
  logic                  do_push, do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage is not reset; occupancy tracking makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      level_q <= level_d;
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (do_pop) begin
        head_q   <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      end
    end
  end

  assign level = level_q;
  assign head  = head_q;

endmodule

// File: rtl/audio_smpl_buffer.sv
// Elastic sample buffer and sample-rate timing source feeding the
// sigma-delta DAC wrapper. Bursty samples are queued in a FIFO and
// released one per sample period, after a priming fill.
// Ports:
//   clk, reset         - clock, asynchronous active-low reset
//   in_valid, in_smpl  - upstream sample handshake; in_ready = !full
//   smpl_rdy, smpl     - one-cycle strobe with the sample for the DAC
//   smpl_rate_trig     - one-cycle strobe on the last count of a period
//   fill_level         - FIFO occupancy
//   clr_flags          - clears the sticky underflow/overflow flags
//   underflow          - a RUN pop slot found the FIFO empty
//   overflow           - a sample arrived while full and was dropped
module audio_smpl_buffer
  import audio_pkg::*;
#(
  parameter int unsigned RATE_DIV       = RATE_DIV_DEFAULT,
  parameter int unsigned DEPTH_LOG2     = 4,
  parameter int unsigned PRIME_LVL      = 4,
  parameter bit          UNDERFLOW_ZERO = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [SMPL_W-1:0]   in_smpl,
  output logic                in_ready,
  output logic                smpl_rdy,
  output logic [SMPL_W-1:0]   smpl,
  output logic                smpl_rate_trig,
  output logic [DEPTH_LOG2:0] fill_level,
  input  logic                clr_flags,
  output logic                underflow,
  output logic                overflow
);

  localparam int unsigned CNT_W = $clog2(RATE_DIV);
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pop_slot;
  logic              state_q, state_d;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [SMPL_W-1:0] fifo_head;
  logic [LVL_W-1:0]  fifo_level;
  logic              emit_data, emit_zero, uf_set, of_set;
  logic              smpl_rdy_q, zero_q, underflow_q, overflow_q;

  // Rate counter runs in every state.
  assign smpl_rate_trig = (cnt_q == CNT_W'(RATE_DIV - 1));
  assign pop_slot       = (cnt_q == '0);
  assign cnt_d          = smpl_rate_trig ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  assign of_set    = in_valid && fifo_full;

  smpl_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (SMPL_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(in_smpl),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .head     (fifo_head)
  );

  // FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_PRIME;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PRIME: if (fifo_level >= LVL_W'(PRIME_LVL)) state_d = ST_RUN;
      ST_RUN:   if (pop_slot && fifo_empty) state_d = ST_PRIME;
      default:  state_d = ST_PRIME;
    endcase
  end

  // FSM: outputs. A push landing in an empty FIFO during the slot is not
  // bypassed, because the pop decision uses the registered empty flag.
  always_comb begin
    fifo_pop  = 1'b0;
    emit_data = 1'b0;
    emit_zero = 1'b0;
    uf_set    = 1'b0;
    if (pop_slot) begin
      if (state_q == ST_RUN && !fifo_empty) begin
        fifo_pop  = 1'b1;
        emit_data = 1'b1;
      end else begin
        emit_zero = UNDERFLOW_ZERO;
        uf_set    = (state_q == ST_RUN);
      end
    end
  end

  // zero_q masks the FIFO read register after a zero emission so smpl holds
  // zero until the next real pop; the read register itself only moves on pops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smpl_rdy_q  <= 1'b0;
      zero_q      <= 1'b1;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      smpl_rdy_q <= emit_data || emit_zero;
      if (emit_data) begin
        zero_q <= 1'b0;
      end else if (emit_zero) begin
        zero_q <= 1'b1;
      end
      // Set wins over a coincident clear.
      underflow_q <= uf_set || (underflow_q && !clr_flags);
      overflow_q  <= of_set || (overflow_q && !clr_flags);
    end
  end

  assign smpl_rdy   = smpl_rdy_q;
  assign smpl       = zero_q ? '0 : fifo_head;
  assign fill_level = fifo_level;
  assign underflow  = underflow_q;
  assign overflow   = overflow_q;

endmodule
